// File: rtl/stream_siso_iter_ctrl.sv
// Turbo iteration controller: hard decisions on SISO output, early stop on a stable full iteration, bit readout.
// Optional STREAM_SISO_ITER_CTRL_STATS_EN adds last_mismatch / total_half_iters outputs.
module stream_siso_iter_ctrl #(
  parameter int unsigned BITS            = 16,
  parameter int unsigned BITS_PER_SYMBOL = 2,
  parameter int unsigned DECISION_INDEX  = 1,
  parameter int unsigned SYMBOLS         = 10,
  parameter int unsigned MAX_ITER        = 8,
  parameter int unsigned MIN_ITER        = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 in_valid,
  input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0] llr_in,
  output logic                                 busy,
  output logic                                 half_iter,
  output logic [7:0]                           iter_count,
  output logic                                 converged,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 result,
  output logic                                 out_last,
  output logic                                 done
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
  ,
  output logic [7:0]                           last_mismatch,
  output logic [9:0]                           total_half_iters
`endif
);

  localparam int unsigned SW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [SW-1:0] LAST_SYM = SW'(SYMBOLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, READOUT} state_e;

  state_e             state_q, state_d;
  logic               half_iter_q, half_iter_d;
  logic [7:0]         iter_count_q, iter_count_d;
  logic               converged_q, converged_d;
  logic [SW-1:0]      sym_q, sym_d;
  logic [7:0]         mism_q, mism_d;
  logic [SYMBOLS-1:0] dec_buf_q, dec_buf_d;
  logic               out_valid_q, out_valid_d;
  logic [SW-1:0]      rd_q, rd_d;
  logic               done_q, done_d;

`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
  logic [7:0]         last_mism_q, last_mism_d;
  logic [9:0]         total_q, total_d;
`endif

  logic       dec;
  logic       mis_now;
  logic       blk_end;
  logic [7:0] mism_inc;
  logic [7:0] iter_next;
  logic       llr_unused;

  // Only the sign of the selected LLR matters; a zero word decodes as 1.
  assign dec        = ~llr_in[DECISION_INDEX][BITS-1];
  assign llr_unused = ^llr_in;

  always_comb begin
    state_d      = state_q;
    half_iter_d  = half_iter_q;
    iter_count_d = iter_count_q;
    converged_d  = converged_q;
    sym_d        = sym_q;
    mism_d       = mism_q;
    dec_buf_d    = dec_buf_q;
    out_valid_d  = out_valid_q;
    rd_d         = rd_q;
    done_d       = 1'b0;
    mis_now      = 1'b0;
    blk_end      = 1'b0;
    mism_inc     = mism_q;
    iter_next    = iter_count_q + 8'd1;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
    last_mism_d  = last_mism_q;
    total_d      = total_q;
`endif

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (in_valid) begin
          blk_end = (sym_q == LAST_SYM);
          sym_d   = blk_end ? '0 : sym_q + 1'b1;
          if (half_iter_q) begin
            // Stale buffer contents from an aborted codeword are masked until iteration 1 is stored.
            mis_now = (iter_count_q != 8'd0) && (dec != dec_buf_q[sym_q]);
            if (mis_now && (mism_q != 8'hFF)) mism_inc = mism_q + 8'd1;
            mism_d           = mism_inc;
            dec_buf_d[sym_q] = dec;
            if (blk_end) begin
              iter_count_d = iter_next;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
              last_mism_d = mism_inc;
`endif
              if ((iter_next >= 8'(MIN_ITER)) && (mism_inc == 8'd0)) begin
                converged_d = 1'b1;
                state_d     = READOUT;
                out_valid_d = 1'b1;
                rd_d        = '0;
              end else if (iter_next == 8'(MAX_ITER)) begin
                converged_d = 1'b0;
                state_d     = READOUT;
                out_valid_d = 1'b1;
                rd_d        = '0;
              end else begin
                half_iter_d = 1'b0;
                mism_d      = '0;
              end
            end
          end else if (blk_end) begin
            half_iter_d = 1'b1;
          end
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
          if (blk_end) total_d = total_q + 10'd1;
`endif
        end
      end
      READOUT: begin
        if (out_valid_q && out_ready) begin
          if (rd_q == LAST_SYM) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // start overrides everything above, including a coincident block end or final transfer.
    if (start) begin
      state_d      = RUN;
      half_iter_d  = 1'b0;
      iter_count_d = '0;
      converged_d  = 1'b0;
      sym_d        = '0;
      mism_d       = '0;
      out_valid_d  = 1'b0;
      rd_d         = '0;
      done_d       = 1'b0;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
      last_mism_d  = '0;
      total_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      half_iter_q  <= 1'b0;
      iter_count_q <= '0;
      converged_q  <= 1'b0;
      sym_q        <= '0;
      mism_q       <= '0;
      dec_buf_q    <= '0;
      out_valid_q  <= 1'b0;
      rd_q         <= '0;
      done_q       <= 1'b0;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
      last_mism_q  <= '0;
      total_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      half_iter_q  <= half_iter_d;
      iter_count_q <= iter_count_d;
      converged_q  <= converged_d;
      sym_q        <= sym_d;
      mism_q       <= mism_d;
      dec_buf_q    <= dec_buf_d;
      out_valid_q  <= out_valid_d;
      rd_q         <= rd_d;
      done_q       <= done_d;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
      last_mism_q  <= last_mism_d;
      total_q      <= total_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign half_iter  = half_iter_q;
  assign iter_count = iter_count_q;
  assign converged  = converged_q;
  assign out_valid  = out_valid_q;
  assign result     = out_valid_q & dec_buf_q[rd_q];
  assign out_last   = out_valid_q & (rd_q == LAST_SYM);
  assign done       = done_q;
`ifdef STREAM_SISO_ITER_CTRL_STATS_EN
  assign last_mismatch    = last_mism_q;
  assign total_half_iters = total_q;
`endif

endmodule

// File: tb/tb_stream_siso_iter_ctrl.sv
// Self-checking bench for stream_siso_iter_ctrl: scoreboard of expected readout bits, one task per scenario.
module tb_stream_siso_iter_ctrl;

  localparam int unsigned SYM = 10;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready;
  logic [1:0][15:0] llr_in;
  logic             busy, half_iter, converged, out_valid, result, out_last, done;
  logic [7:0]       iter_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] blkw [0:15][0:SYM-1];
  logic        sb [$];

  always #5 clk = ~clk;

  stream_siso_iter_ctrl #(
    .BITS(16), .BITS_PER_SYMBOL(2), .DECISION_INDEX(1),
    .SYMBOLS(SYM), .MAX_ITER(8), .MIN_ITER(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .llr_in(llr_in),
    .busy(busy), .half_iter(half_iter), .iter_count(iter_count), .converged(converged),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_last(out_last),
    .done(done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bit=1 -> non-negative word, bit=0 -> negative word, random magnitudes.
  task automatic fill_block(input int b, input logic [SYM-1:0] bits);
    for (int s = 0; s < SYM; s++)
      blkw[b][s] = bits[s] ? 16'($urandom_range(0, 32767)) : (16'h8000 | 16'($urandom_range(0, 32767)));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL start_iter got=%0d exp=0", iter_count); end
    checks++; if (half_iter !== 1'b0) begin errors++; $display("FAIL start_half got=%b exp=0", half_iter); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_ovalid got=%b exp=0", out_valid); end
  endtask

  task automatic feed(input int first, input int nblk, input bit is_final);
    for (int b = first; b < first + nblk; b++) begin
      for (int s = 0; s < SYM; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid  = 1'b0;
          llr_in[1] = 16'($urandom);
          @(posedge clk); #1;
        end
        llr_in[1] = blkw[b][s];
        llr_in[0] = 16'($urandom);
        in_valid  = 1'b1;
        if (is_final && b == first + nblk - 1) sb.push_back(~blkw[b][s][15]);
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      if (!(is_final && b == first + nblk - 1)) begin
        checks++; if (half_iter !== 1'((b + 1) % 2)) begin errors++; $display("FAIL blk%0d_half got=%b exp=%0d", b, half_iter, (b + 1) % 2); end
        checks++; if (iter_count !== 8'((b + 1) / 2)) begin errors++; $display("FAIL blk%0d_iter got=%0d exp=%0d", b, iter_count, (b + 1) / 2); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL blk%0d_run got ov=%b busy=%b exp ov=0 busy=1", b, out_valid, busy); end
      end
    end
    if (is_final) begin
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL term_ovalid got ov=%b busy=%b exp 1 1", out_valid, busy); end
    end
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1.
  task automatic drain(input int mode, input int nexp, input bit is_final);
    int   n = 0;
    logic stall = 1'b0;
    logic held_r = 1'b0, held_l = 1'b0;
    logic exp_b;
    for (int c = 0; c < 200 && n < nexp; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got=%b exp=1 at bit %0d", out_valid, n); end
      if (stall) begin
        checks++; if (result !== held_r || out_last !== held_l) begin errors++; $display("FAIL stall_stable got r=%b l=%b exp r=%b l=%b", result, out_last, held_r, held_l); end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL sb_empty got=transfer exp=none");
        end else begin
          exp_b = sb.pop_front();
          checks++; if (result !== exp_b) begin errors++; $display("FAIL rd_bit%0d got=%b exp=%b", n, result, exp_b); end
        end
        checks++; if (out_last !== (n == SYM - 1)) begin errors++; $display("FAIL rd_last%0d got=%b exp=%b", n, out_last, n == SYM - 1); end
        n++;
        stall = 1'b0;
      end else begin
        stall  = 1'b1;
        held_r = result;
        held_l = out_last;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (n != nexp) begin errors++; $display("FAIL rd_count got=%0d exp=%0d", n, nexp); end
    if (is_final) begin
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", done); end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_rd got ov=%b busy=%b exp 0 0", out_valid, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_once got=%b exp=0", done); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; llr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, half_iter, converged, out_valid, result, out_last, done} !== 7'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000000", {busy, half_iter, converged, out_valid, result, out_last, done}); end
    checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter got=%0d exp=0", iter_count); end
    rst = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore got busy=%b exp=0", busy); end
  endtask

  task automatic test_converge();
    for (int b = 0; b < 4; b++) fill_block(b, '1);
    do_start();
    feed(0, 4, 1);
    checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL conv_iter got=%0d exp=2", iter_count); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL conv_flag got=%b exp=1", converged); end
    drain(0, SYM, 1);
    checks++; if (iter_count !== 8'd2 || converged !== 1'b1) begin errors++; $display("FAIL conv_hold got it=%0d cv=%b exp 2 1", iter_count, converged); end
  endtask

  task automatic test_max_iter();
    logic [SYM-1:0] p;
    p = SYM'($urandom);
    for (int b = 0; b < 16; b++) fill_block(b, ((b / 2) % 2 == 0) ? p : ~p);
    do_start();
    feed(0, 16, 1);
    checks++; if (iter_count !== 8'd8) begin errors++; $display("FAIL max_iter got=%0d exp=8", iter_count); end
    checks++; if (converged !== 1'b0) begin errors++; $display("FAIL max_conv got=%b exp=0", converged); end
    drain(0, SYM, 1);
  endtask

  task automatic test_stall();
    logic [SYM-1:0] q;
    q = SYM'($urandom);
    for (int b = 0; b < 4; b++) fill_block(b, q);
    do_start();
    feed(0, 4, 1);
    drain(1, SYM, 1);
  endtask

  task automatic test_half_precision();
    logic [SYM-1:0] q;
    q = SYM'($urandom);
    for (int b = 0; b < 4; b++) begin
      fill_block(b, q);
      blkw[b][0] = 16'h0000;
      blkw[b][1] = 16'h8000;
      blkw[b][2] = 16'h7BFF;
    end
    do_start();
    feed(0, 4, 1);
    checks++; if (sb.size() != SYM || sb[0] !== 1'b1 || sb[1] !== 1'b0 || sb[2] !== 1'b1) begin errors++; $display("FAIL half_model got=%0d entries exp=%0d with 1,0,1 head", sb.size(), SYM); end
    drain(0, SYM, 1);
  endtask

  task automatic test_rst_mid();
    logic [SYM-1:0] p;
    p = SYM'($urandom);
    for (int b = 0; b < 5; b++) fill_block(b, ((b / 2) % 2 == 0) ? p : ~p);
    do_start();
    feed(0, 4, 0);
    for (int s = 0; s < 3; s++) begin
      llr_in[1] = blkw[4][s]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; llr_in[1] = blkw[4][3];
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || half_iter !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got busy=%b ov=%b hi=%b dn=%b exp 0 0 0 0", busy, out_valid, half_iter, done); end
    checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL rst_mid_iter got=%0d exp=0", iter_count); end
    for (int b = 0; b < 4; b++) fill_block(b, p);
    do_start();
    feed(0, 4, 1);
    checks++; if (iter_count !== 8'd2 || converged !== 1'b1) begin errors++; $display("FAIL rst_reconv got it=%0d cv=%b exp 2 1", iter_count, converged); end
    drain(0, SYM, 1);
  endtask

  task automatic test_abort();
    for (int b = 0; b < 4; b++) fill_block(b, '1);
    do_start();
    feed(0, 4, 1);
    drain(0, 4, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_out got ov=%b dn=%b exp 0 0", out_valid, done); end
    checks++; if (busy !== 1'b1 || iter_count !== 8'd0 || converged !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b it=%0d cv=%b exp 1 0 0", busy, iter_count, converged); end
    sb.delete();
    for (int b = 0; b < 4; b++) fill_block(b, '0);
    feed(0, 2, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone got=%b exp=0", done); end
    feed(2, 2, 1);
    checks++; if (iter_count !== 8'd2 || converged !== 1'b1) begin errors++; $display("FAIL abort_reconv got it=%0d cv=%b exp 2 1", iter_count, converged); end
    drain(0, SYM, 1);
  endtask

  initial begin
    test_reset();
    test_converge();
    test_max_iter();
    test_stall();
    test_half_precision();
    test_rst_mid();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
